// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller.
// No logic of its own: widths, size codes and FSM encoding only.
// Imported by mem_ctrl; the helper has no timing or flow-control behaviour.
package mem_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 32;

    // Access size code; byte count is code + 1
    typedef enum logic [1:0] {
        STAGE_B = 2'b00,
        STAGE_H = 2'b01,
        STAGE_T = 2'b10,
        STAGE_W = 2'b11
    } stage_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Which requester owns the transaction in flight
    typedef enum logic [1:0] {
        SRC_MEM_RD = 2'b00,
        SRC_MEM_WR = 2'b01,
        SRC_IF     = 2'b10
    } src_t;

    // Number of bytes moved for a given size code (1..4)
    function automatic logic [2:0] byte_count(input logic [1:0] stage);
        return {1'b0, stage} + 3'd1;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates MEM load/store and instruction fetch onto a byte-wide synchronous RAM.
// Latency: read done at T+N+2, write done at T+N+1 after acceptance cycle T.
// Backpressure: one transaction at a time; requests are only sampled in IDLE and must be held until then.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_re_req,
    input  logic              mem_wr_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_stage,
    input  logic [31:0]       mem_wr_data,
    output logic [31:0]       mem_re_data,
    output logic              mem_re_done,
    output logic              mem_wr_done,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_dout,
    output logic              ram_wr,
    input  logic [DATA_W-1:0] ram_din
);

    state_t              state, state_nx;
    src_t                src_r, src_nx;
    logic [ADDR_W-1:0]   addr_r, addr_nx;
    logic [2:0]          n_r, n_nx;
    logic [2:0]          i_r, i_nx;
    logic [31:0]         wdat_r, wdat_nx;
    logic [31:0]         asm_r, asm_nx;

    logic [ADDR_W-1:0]   ram_a_nx;
    logic [DATA_W-1:0]   ram_dout_nx;
    logic                ram_wr_nx;
    logic                mem_re_done_nx, mem_wr_done_nx, if_done_nx;
    logic [31:0]         mem_re_data_nx, if_data_nx;

    // i_r is the byte index on the address bus; the RAM returns it one cycle later
    logic [2:0]          i_inc;
    logic [1:0]          lane;
    assign i_inc = i_r + 3'd1;
    assign lane  = i_r[1:0] - 2'd1;

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_nx       = state;
        src_nx         = src_r;
        addr_nx        = addr_r;
        n_nx           = n_r;
        i_nx           = i_r;
        wdat_nx        = wdat_r;
        asm_nx         = asm_r;
        ram_a_nx       = '0;
        ram_dout_nx    = '0;
        ram_wr_nx      = 1'b0;
        mem_re_done_nx = 1'b0;
        mem_wr_done_nx = 1'b0;
        if_done_nx     = 1'b0;
        mem_re_data_nx = mem_re_data;
        if_data_nx     = if_data;

        case (state)
            IDLE: begin
                if (mem_wr_req) begin
                    state_nx    = WRITE;
                    src_nx      = SRC_MEM_WR;
                    addr_nx     = mem_addr;
                    n_nx        = byte_count(mem_stage);
                    wdat_nx     = mem_wr_data;
                    i_nx        = 3'd0;
                    ram_wr_nx   = 1'b1;
                    ram_a_nx    = mem_addr;
                    ram_dout_nx = mem_wr_data[7:0];
                end else if (mem_re_req) begin
                    state_nx = READ;
                    src_nx   = SRC_MEM_RD;
                    addr_nx  = mem_addr;
                    n_nx     = byte_count(mem_stage);
                    i_nx     = 3'd0;
                    asm_nx   = '0;
                    ram_a_nx = mem_addr;
                end else if (if_req) begin
                    state_nx = READ;
                    src_nx   = SRC_IF;
                    addr_nx  = if_addr;
                    n_nx     = 3'd4;
                    i_nx     = 3'd0;
                    asm_nx   = '0;
                    ram_a_nx = if_addr;
                end
            end

            READ: begin
                // Byte i_r-1 is on ram_din this cycle
                if (i_r != 3'd0) begin
                    asm_nx[{lane, 3'b000} +: 8] = ram_din;
                end
                if (i_r == n_r) begin
                    state_nx = DONE;
                    if (src_r == SRC_IF) begin
                        if_done_nx = 1'b1;
                        if_data_nx = asm_nx;
                    end else begin
                        mem_re_done_nx = 1'b1;
                        mem_re_data_nx = asm_nx;
                    end
                end else if (i_inc == n_r) begin
                    // Last address already issued; spend one cycle catching its data
                    i_nx = i_inc;
                end else begin
                    i_nx     = i_inc;
                    ram_a_nx = addr_r + {{(ADDR_W-3){1'b0}}, i_inc};
                end
            end

            WRITE: begin
                if (i_inc == n_r) begin
                    state_nx       = DONE;
                    mem_wr_done_nx = 1'b1;
                end else begin
                    i_nx        = i_inc;
                    ram_wr_nx   = 1'b1;
                    ram_a_nx    = addr_r + {{(ADDR_W-3){1'b0}}, i_inc};
                    ram_dout_nx = wdat_r[{i_inc[1:0], 3'b000} +: 8];
                end
            end

            DONE: begin
                // Single-cycle gap so a held request is re-sampled as a new transaction
                state_nx = IDLE;
            end

            default: state_nx = IDLE;
        endcase
    end

    // State, datapath and output registers; reset aborts silently
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            src_r       <= SRC_MEM_RD;
            addr_r      <= '0;
            n_r         <= '0;
            i_r         <= '0;
            wdat_r      <= '0;
            asm_r       <= '0;
            ram_a       <= '0;
            ram_dout    <= '0;
            ram_wr      <= 1'b0;
            mem_re_done <= 1'b0;
            mem_wr_done <= 1'b0;
            if_done     <= 1'b0;
            mem_re_data <= '0;
            if_data     <= '0;
        end else begin
            state       <= state_nx;
            src_r       <= src_nx;
            addr_r      <= addr_nx;
            n_r         <= n_nx;
            i_r         <= i_nx;
            wdat_r      <= wdat_nx;
            asm_r       <= asm_nx;
            ram_a       <= ram_a_nx;
            ram_dout    <= ram_dout_nx;
            ram_wr      <= ram_wr_nx;
            mem_re_done <= mem_re_done_nx;
            mem_wr_done <= mem_wr_done_nx;
            if_done     <= if_done_nx;
            mem_re_data <= mem_re_data_nx;
            if_data     <= if_data_nx;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed transactions push expected events,
// a negedge monitor pops and compares every write beat and done pulse.
// A byte-wide synchronous RAM model sits on the RAM port.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_re_req, mem_wr_req;
    logic [31:0] mem_addr;
    logic [1:0]  mem_stage;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_re_data;
    logic        mem_re_done, mem_wr_done;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_re_req(mem_re_req), .mem_wr_req(mem_wr_req),
        .mem_addr(mem_addr), .mem_stage(mem_stage), .mem_wr_data(mem_wr_data),
        .mem_re_data(mem_re_data), .mem_re_done(mem_re_done), .mem_wr_done(mem_wr_done),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous byte RAM model
    logic [7:0] ram [int unsigned];
    always @(posedge clk) begin
        if (ram_wr) ram[ram_a] = ram_dout;
        ram_din <= ram.exists(ram_a) ? ram[ram_a] : 8'h00;
    end

    typedef struct { bit is_if; logic [31:0] data; int cyc; } rd_exp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; int cyc; } wr_exp_t;
    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    int      wd_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event with no expected entry (cycle %0d)", nm, cyc);
    endtask

    // Monitor: compare whatever the DUT presents against the scoreboard heads
    rd_exp_t re;
    wr_exp_t we;
    int      wc;
    int      ndone;
    always @(negedge clk) begin
        if (rst) begin
            ndone = int'(mem_re_done) + int'(mem_wr_done) + int'(if_done);
            if (ndone != 0) chk("done_exclusive", ndone, 1);
            if (ram_wr) begin
                if (wr_q.size() == 0) unexpected("ram_wr");
                else begin
                    we = wr_q.pop_front();
                    chk("wr_addr", ram_a, we.a);
                    chk("wr_data", {24'h0, ram_dout}, {24'h0, we.d});
                    chk("wr_cycle", cyc, we.cyc);
                end
            end
            if (mem_re_done || if_done) begin
                if (rd_q.size() == 0) unexpected("read_done");
                else begin
                    re = rd_q.pop_front();
                    chk("rd_is_if", {31'h0, if_done}, {31'h0, re.is_if});
                    chk("rd_data", if_done ? if_data : mem_re_data, re.data);
                    chk("rd_cycle", cyc, re.cyc);
                end
            end
            if (mem_wr_done) begin
                if (wd_q.size() == 0) unexpected("mem_wr_done");
                else begin
                    wc = wd_q.pop_front();
                    chk("wr_done_cycle", cyc, wc);
                end
            end
        end
    end

    // Load from MEM (is_if=0) or fetch (is_if=1); returns at negedge of the done cycle
    task automatic load(input bit is_if, input logic [31:0] a, input logic [1:0] st,
                        input logic [31:0] exp_d);
        int n;
        n = is_if ? 4 : int'(st) + 1;
        @(negedge clk);
        if (is_if) begin if_req = 1'b1; if_addr = a; end
        else begin mem_re_req = 1'b1; mem_addr = a; mem_stage = st; end
        rd_q.push_back('{is_if, exp_d, cyc + n + 2});
        @(negedge clk);
        if_req = 1'b0;
        mem_re_req = 1'b0;
        repeat (n + 1) @(negedge clk);
    endtask

    // Store with hand-listed expected beats; returns at negedge of the done cycle
    task automatic store(input logic [31:0] a, input logic [1:0] st, input logic [31:0] d,
                         input logic [3:0][31:0] ea, input logic [3:0][7:0] ed);
        int n;
        n = int'(st) + 1;
        @(negedge clk);
        mem_wr_req = 1'b1; mem_addr = a; mem_stage = st; mem_wr_data = d;
        for (int k = 0; k < n; k++) wr_q.push_back('{ea[k], ed[k], cyc + 1 + k});
        wd_q.push_back(cyc + n + 1);
        @(negedge clk);
        mem_wr_req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c;
        rst = 1'b0;
        mem_re_req = 0; mem_wr_req = 0; if_req = 0;
        mem_addr = 0; mem_stage = 0; mem_wr_data = 0; if_addr = 0;
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        ram[32'h10]  = 8'hAB; ram[32'h11]  = 8'hCD;
        ram[32'h0]   = 8'h01; ram[32'h1]   = 8'h02; ram[32'h2]   = 8'h03; ram[32'h3]   = 8'h04;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ram_wr", {31'h0, ram_wr}, 32'h0);
        chk("rst_ram_a", ram_a, 32'h0);
        chk("rst_ram_dout", {24'h0, ram_dout}, 32'h0);
        chk("rst_dones", {29'h0, mem_re_done, mem_wr_done, if_done}, 32'h0);
        chk("rst_re_data", mem_re_data, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        rst = 1'b1;

        // Word load, byte store, narrow loads
        load(0, 32'h100, 2'b11, 32'h44332211);
        store(32'h200, 2'b00, 32'hDEADBEEF, {32'h0, 32'h0, 32'h0, 32'h200}, {8'h0, 8'h0, 8'h0, 8'hEF});
        load(0, 32'h103, 2'b00, 32'h00000044);
        load(0, 32'h101, 2'b10, 32'h00443322);

        // Fetch and half-load together: MEM first, IF on the following IDLE
        @(negedge clk);
        c = cyc;
        mem_re_req = 1'b1; mem_addr = 32'h10; mem_stage = 2'b01;
        if_req = 1'b1; if_addr = 32'h0;
        rd_q.push_back('{1'b0, 32'h0000CDAB, c + 4});
        rd_q.push_back('{1'b1, 32'h04030201, c + 11});
        @(negedge clk);
        mem_re_req = 1'b0;
        repeat (10) @(negedge clk);
        if_req = 1'b0;

        // Word store across the top of the address space, then read it back
        store(32'hFFFF_FFFE, 2'b11, 32'h12345678,
              {32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE}, {8'h12, 8'h34, 8'h56, 8'h78});
        load(0, 32'hFFFF_FFFE, 2'b11, 32'h12345678);
        load(1, 32'h0, 2'b11, 32'h04031234);

        // Reset during byte 2 of a load: no done, then a fresh load right after release
        @(negedge clk);
        mem_re_req = 1'b1; mem_addr = 32'h100; mem_stage = 2'b11;
        @(negedge clk);
        mem_re_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ram_wr", {31'h0, ram_wr}, 32'h0);
        chk("abort_ram_a", ram_a, 32'h0);
        chk("abort_done", {31'h0, mem_re_done}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mem_re_req = 1'b1; mem_addr = 32'h100; mem_stage = 2'b11;
        rd_q.push_back('{1'b0, 32'h44332211, cyc + 6});
        @(negedge clk);
        mem_re_req = 1'b0;
        repeat (5) @(negedge clk);

        // Held request: two separate half-word loads
        @(negedge clk);
        c = cyc;
        mem_re_req = 1'b1; mem_addr = 32'h100; mem_stage = 2'b01;
        rd_q.push_back('{1'b0, 32'h00002211, c + 4});
        rd_q.push_back('{1'b0, 32'h00002211, c + 9});
        repeat (9) @(negedge clk);
        mem_re_req = 1'b0;

        // Drain: nothing outstanding, nothing extra
        repeat (12) @(negedge clk);
        chk("rd_q_empty", rd_q.size(), 32'h0);
        chk("wr_q_empty", wr_q.size(), 32'h0);
        chk("wd_q_empty", wd_q.size(), 32'h0);
        chk("idle_ram_wr", {31'h0, ram_wr}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
